// File: rtl/cla_seq_pkg.sv
// Shared constants and state type for the sequential carry-lookahead adder controller.
package cla_seq_pkg;

    localparam int SLICE_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        HOLD = ST_HOLD
    } state_t;

endpackage

// File: rtl/cla_seq_adder_ctrl_if.sv
// Operand/result handshake bundle for cla_seq_adder_ctrl.
// The ovf signal exists only when CLA_SEQ_OVF_EN is defined.
interface cla_seq_adder_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef CLA_SEQ_OVF_EN
    logic             ovf;
`endif

    // Producer/consumer side
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
`ifdef CLA_SEQ_OVF_EN
        , input ovf
`endif
    );

    // Controller side
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
`ifdef CLA_SEQ_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/cla_seq_adder_ctrl_slice.sv
// 4-bit combinational carry-lookahead adder slice reused by the sequencer.
module carry_lk_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is expanded from generate/propagate terms instead of rippling
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s    = p ^ c[3:0];
    assign cout = c[4];
endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// Multi-cycle wide adder: one 4-bit CLA slice walks the operands LSB slice first.
// Optional signed-overflow output enabled by defining CLA_SEQ_OVF_EN.
module cla_seq_adder_ctrl
    import cla_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cla_seq_adder_ctrl_if.slave  bus
);
    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] aOp_q, aOp_d;
    logic [WIDTH-1:0] bOp_q, bOp_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             outValid_q, outValid_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [SLICE_W-1:0] sliceA, sliceB, sliceS;
    logic               sliceCout;

    assign sliceA = aOp_q[idx_q*SLICE_W +: SLICE_W];
    assign sliceB = bOp_q[idx_q*SLICE_W +: SLICE_W];

    carry_lk_adder u_slice (
        .a    (sliceA),
        .b    (sliceB),
        .cin  (carry_q),
        .s    (sliceS),
        .cout (sliceCout)
    );

`ifdef CLA_SEQ_OVF_EN
    logic ovf_q, ovf_d;
    logic msbCarryIn;

    // Carry into the MSB recovered from the top bit's sum equation
    assign msbCarryIn = sliceA[SLICE_W-1] ^ sliceB[SLICE_W-1] ^ sliceS[SLICE_W-1];
    assign bus.ovf    = ovf_q;
`endif

    always_comb begin
        state_d    = state_q;
        aOp_d      = aOp_q;
        bOp_d      = bOp_q;
        sum_d      = sum_q;
        carry_d    = carry_q;
        cout_d     = cout_q;
        outValid_d = outValid_q;
        idx_d      = idx_q;
`ifdef CLA_SEQ_OVF_EN
        ovf_d      = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    aOp_d   = bus.a;
                    bOp_d   = bus.b;
                    carry_d = bus.cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q*SLICE_W +: SLICE_W] = sliceS;
                carry_d = sliceCout;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    cout_d     = sliceCout;
                    outValid_d = 1'b1;
                    state_d    = HOLD;
`ifdef CLA_SEQ_OVF_EN
                    ovf_d      = msbCarryIn ^ sliceCout;
`endif
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    outValid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aOp_q      <= '0;
            bOp_q      <= '0;
            sum_q      <= '0;
            carry_q    <= 1'b0;
            cout_q     <= 1'b0;
            outValid_q <= 1'b0;
            idx_q      <= '0;
`ifdef CLA_SEQ_OVF_EN
            ovf_q      <= 1'b0;
`endif
        end else begin
            aOp_q      <= aOp_d;
            bOp_q      <= bOp_d;
            sum_q      <= sum_d;
            carry_q    <= carry_d;
            cout_q     <= cout_d;
            outValid_q <= outValid_d;
            idx_q      <= idx_d;
`ifdef CLA_SEQ_OVF_EN
            ovf_q      <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = outValid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Scoreboard bench for cla_seq_adder_ctrl (WIDTH=16); checks ovf when CLA_SEQ_OVF_EN is defined.
module tb_cla_seq_adder_ctrl;
    localparam int WIDTH  = 16;
    localparam int NSLICE = WIDTH / 4;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   errCount   = 0;
    int   checkCount = 0;
    int   cyc        = 0;
    int   acceptCyc  = 0;
    exp_t sb[$];

    cla_seq_adder_ctrl_if #(.WIDTH(WIDTH)) ifc ();

    cla_seq_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one operand pair, push its reference result, return just after the accepting edge
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
        logic [WIDTH:0] full;
        exp_t           e;
        int             n;
        full   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        e.sum  = full[WIDTH-1:0];
        e.cout = full[WIDTH];
        e.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (e.sum[WIDTH-1] != a[WIDTH-1]);
        sb.push_back(e);
        @(negedge clk);
        ifc.in_valid = 1'b1;
        ifc.a        = a;
        ifc.b        = b;
        ifc.cin      = cin;
        n = 0;
        while (!ifc.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) checkOutput("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        acceptCyc    = cyc;
        ifc.in_valid = 1'b0;
    endtask

    // Wait for a result, compare against the scoreboard, stall holdCycles, then retire it
    task automatic waitResult(input int holdCycles);
        exp_t e;
        int   n;
        n = 0;
        while (!ifc.out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!ifc.out_valid) begin
            checkOutput("result_timeout", 32'd0, 32'd1);
            return;
        end
        if (sb.size() == 0) begin
            checkOutput("sb_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        checkOutput("latency", 32'(cyc - acceptCyc), NSLICE);
        checkOutput("sum", 32'(ifc.sum), 32'(e.sum));
        checkOutput("cout", 32'(ifc.cout), 32'(e.cout));
        checkOutput("busy_hold", 32'(ifc.busy), 32'd1);
        checkOutput("in_ready_hold", 32'(ifc.in_ready), 32'd0);
`ifdef CLA_SEQ_OVF_EN
        checkOutput("ovf", 32'(ifc.ovf), 32'(e.ovf));
`endif
        for (int i = 0; i < holdCycles; i++) begin
            @(negedge clk);
            checkOutput("hold_valid", 32'(ifc.out_valid), 32'd1);
            checkOutput("hold_sum", 32'(ifc.sum), 32'(e.sum));
            checkOutput("hold_cout", 32'(ifc.cout), 32'(e.cout));
        end
        ifc.out_ready = 1'b1;
        @(posedge clk);
        #1;
        ifc.out_ready = 1'b0;
        @(negedge clk);
        checkOutput("valid_drop", 32'(ifc.out_valid), 32'd0);
        checkOutput("in_ready_back", 32'(ifc.in_ready), 32'd1);
        checkOutput("busy_idle", 32'(ifc.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.a         = '0;
        ifc.b         = '0;
        ifc.cin       = 1'b0;
        ifc.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", 32'(ifc.in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        checkOutput("rst_sum", 32'(ifc.sum), 32'd0);
        checkOutput("rst_cout", 32'(ifc.cout), 32'd0);
        checkOutput("rst_busy", 32'(ifc.busy), 32'd0);
        rst_n = 1'b1;

        // Zero add and full carry ripple across every slice
        applyStimulus(16'h0000, 16'h0000, 1'b0);
        waitResult(0);
        applyStimulus(16'hFFFF, 16'h0001, 1'b0);
        waitResult(0);

        // Carry-in, with a competing request during RUN that must be ignored
        applyStimulus(16'h1234, 16'h4321, 1'b1);
        @(negedge clk);
        ifc.in_valid = 1'b1;
        ifc.a        = 16'hFFFF;
        ifc.b        = 16'hFFFF;
        ifc.cin      = 1'b1;
        for (int i = 0; i < 2; i++) begin
            checkOutput("run_in_ready", 32'(ifc.in_ready), 32'd0);
            checkOutput("run_busy", 32'(ifc.busy), 32'd1);
            @(negedge clk);
        end
        ifc.in_valid = 1'b0;
        waitResult(0);

        // Backpressure in HOLD
        applyStimulus(16'hA5A5, 16'h5A5B, 1'b0);
        waitResult(3);

        // Asynchronous reset mid-RUN discards the partial result
        applyStimulus(16'h1111, 16'h2222, 1'b0);
        void'(sb.pop_back());
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_in_ready", 32'(ifc.in_ready), 32'd1);
        checkOutput("midrst_out_valid", 32'(ifc.out_valid), 32'd0);
        checkOutput("midrst_sum", 32'(ifc.sum), 32'd0);
        checkOutput("midrst_cout", 32'(ifc.cout), 32'd0);
        checkOutput("midrst_busy", 32'(ifc.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(16'h00FF, 16'h0001, 1'b0);
        waitResult(0);

`ifdef CLA_SEQ_OVF_EN
        applyStimulus(16'h7FFF, 16'h0001, 1'b0);
        waitResult(0);
        applyStimulus(16'hFFFF, 16'h0001, 1'b0);
        waitResult(0);
        applyStimulus(16'h8000, 16'h8000, 1'b0);
        waitResult(0);
`endif

        for (int i = 0; i < 6; i++) begin
            applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
            waitResult(int'($urandom_range(0, 2)));
        end

        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end
endmodule
